// File: rtl/core_seq_pkg.sv
// core_seq_pkg -- shared definitions for the attention-core micro-sequencer.
//   state_e      : sequencer FSM states. NORM_ACC/NORM_WR exist only when
//                  CORE_SEQ_NORM_EN is defined.
//   BIT_*        : fixed bit positions of the low control byte of the packed
//                  core instruction word. The pmem address sits above bit 7.
//                  The qk address sits above the pmem address, and ofifo_rd
//                  is the MSB.
//   SFP_*        : sfp_inst codes.
// Optional feature macro: CORE_SEQ_NORM_EN.
package core_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD_Q,
    ST_LOAD_K,
    ST_KLOAD,
    ST_GAP,
    ST_EXEC,
    ST_DRAIN_RD,
    ST_DRAIN_WR,
`ifdef CORE_SEQ_NORM_EN
    ST_NORM_ACC,
    ST_NORM_WR,
`endif
    ST_DONE
  } state_e;

  localparam int BIT_PMEM_WR      = 0;
  localparam int BIT_PMEM_RD      = 1;
  localparam int BIT_KMEM_WR      = 2;
  localparam int BIT_KMEM_RD      = 3;
  localparam int BIT_QMEM_WR      = 4;
  localparam int BIT_QMEM_RD      = 5;
  localparam int BIT_KLOAD        = 6;
  localparam int BIT_EXEC         = 7;
  localparam int BIT_PMEM_ADDR_LO = 8;

  localparam logic [1:0] SFP_NOP  = 2'b00;
  localparam logic [1:0] SFP_ACC  = 2'b01;
  localparam logic [1:0] SFP_NORM = 2'b10;

  // Width of the packed instruction word for a given address width.
  function automatic int inst_width(input int addr_w);
    return 2 * addr_w + 9;
  endfunction

endpackage

// File: rtl/core_seq_inst_pack.sv
// core_seq_inst_pack -- packs decoded sequencer fields into the core
// instruction word. This block is purely combinational.
//   ofifo_rd  in  1       output-FIFO read (word MSB)
//   qk_addr   in  ADDR_W  q/k memory address
//   pmem_addr in  ADDR_W  psum memory address
//   ctrl      in  8       low control byte, laid out by BIT_* in core_seq_pkg
//   inst      out INST_W  packed word, INST_W = 2*ADDR_W+9
// Optional feature macro: CORE_SEQ_NORM_EN (no effect on this block).
module core_seq_inst_pack
  import core_seq_pkg::*;
#(
  parameter  int ADDR_W = 4,
  localparam int INST_W = 2 * ADDR_W + 9
) (
  input  logic              ofifo_rd,
  input  logic [ADDR_W-1:0] qk_addr,
  input  logic [ADDR_W-1:0] pmem_addr,
  input  logic [7:0]        ctrl,
  output logic [INST_W-1:0] inst
);

  always_comb begin
    inst                                   = '0;
    inst[7:0]                              = ctrl;
    inst[BIT_PMEM_ADDR_LO +: ADDR_W]        = pmem_addr;
    inst[BIT_PMEM_ADDR_LO + ADDR_W +: ADDR_W] = qk_addr;
    inst[INST_W-1]                         = ofifo_rd;
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl -- one-start-per-tile micro-sequencer for a single attention core.
// It walks through the following steps:
//   load-Q -> load-K -> kernel load -> gap -> execute -> psum drain,
//   then optional normalisation, and finally done.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           1-cycle tile start. Ignored unless idle.
//   in_valid        mem_in beat valid, consumed together with in_ready
//   in_ready        high while in LOAD_Q / LOAD_K
//   fifo_valid      core ofifo has a row ready
//   inst            packed core instruction word (INST_W = 2*ADDR_W+9)
//   sfp_inst        01 accumulate, 10 normalise, 00 nop
//   norm_mem_addr   norm memory address
//   norm_mem_wr     norm memory write strobe
//   norm_mem_rd     norm memory read strobe, always 0
//   busy            high from the cycle after an accepted start; low in done's cycle
//   done            one-cycle end-of-tile pulse
// All outputs are registered. Each output reflects the decision made from the
// previous cycle's state and inputs. As a result, a write strobe follows its
// accepted beat by one cycle.
// Optional feature macro: CORE_SEQ_NORM_EN. When it is defined, NORM_ACC and
// NORM_WR run after the drain. When it is undefined, sfp_inst and norm_mem_*
// stay 0.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter  int ADDR_W = 4,
  parameter  int N_Q    = 16,
  parameter  int N_K    = 8,
  localparam int INST_W = 2 * ADDR_W + 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fifo_valid,
  output logic [INST_W-1:0] inst,
  output logic [1:0]        sfp_inst,
  output logic [ADDR_W-1:0] norm_mem_addr,
  output logic              norm_mem_rd,
  output logic              norm_mem_wr,
  output logic              busy,
  output logic              done
);

  // One extra bit so that N_Q = 2**ADDR_W can count to N_Q without wrapping.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  NQ_LAST  = CNT_W'(N_Q - 1);
  localparam logic [CNT_W-1:0]  NQ_END   = CNT_W'(N_Q);
  localparam logic [CNT_W-1:0]  NK_LAST  = CNT_W'(N_K - 1);
  localparam logic [CNT_W-1:0]  NK_END   = CNT_W'(N_K);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(N_Q - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]   cnt_addr;

  logic                ofifo_rd_d;
  logic [ADDR_W-1:0]   qk_addr_d, pmem_addr_d;
  logic [7:0]          ctrl_d;
  logic [INST_W-1:0]   inst_d, inst_q;
  logic [1:0]          sfp_d, sfp_q;
  logic [ADDR_W-1:0]   norm_addr_d, norm_addr_q;
  logic                norm_wr_d, norm_wr_q;
  logic                in_ready_d, in_ready_q;
  logic                busy_d, busy_q;
  logic                done_d, done_q;

  assign cnt_addr = cnt_q[ADDR_W-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    ofifo_rd_d  = 1'b0;
    qk_addr_d   = '0;
    pmem_addr_d = '0;
    ctrl_d      = '0;
    sfp_d       = SFP_NOP;
    norm_wr_d   = 1'b0;
    norm_addr_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_Q;
          cnt_d   = '0;
        end
      end
      ST_LOAD_Q: begin
        if (in_valid && in_ready_q) begin
          ctrl_d[BIT_QMEM_WR] = 1'b1;
          qk_addr_d           = cnt_addr;
          if (cnt_q == NQ_LAST) begin
            cnt_d   = '0;
            state_d = ST_LOAD_K;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_LOAD_K: begin
        if (in_valid && in_ready_q) begin
          ctrl_d[BIT_KMEM_WR] = 1'b1;
          qk_addr_d           = cnt_addr;
          if (cnt_q == NK_LAST) begin
            cnt_d   = '0;
            state_d = ST_KLOAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_KLOAD: begin
        // The extra final cycle keeps kernel-load asserted while the last
        // SRAM read returns.
        ctrl_d[BIT_KLOAD] = 1'b1;
        if (cnt_q != NK_END) begin
          ctrl_d[BIT_KMEM_RD] = 1'b1;
          qk_addr_d           = cnt_addr;
          cnt_d               = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: state_d = ST_EXEC;
      ST_EXEC: begin
        ctrl_d[BIT_EXEC] = 1'b1;
        if (cnt_q != NQ_END) begin
          ctrl_d[BIT_QMEM_RD] = 1'b1;
          qk_addr_d           = cnt_addr;
          cnt_d               = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          row_d   = '0;
          state_d = ST_DRAIN_RD;
        end
      end
      ST_DRAIN_RD: begin
        if (fifo_valid) begin
          ofifo_rd_d = 1'b1;
          state_d    = ST_DRAIN_WR;
        end
      end
      ST_DRAIN_WR: begin
        // This state always separates two reads, so fifo_valid is
        // re-sampled only after the pop has taken effect.
        ctrl_d[BIT_PMEM_WR] = 1'b1;
        pmem_addr_d         = row_q;
        if (row_q == ROW_LAST) begin
          row_d = '0;
`ifdef CORE_SEQ_NORM_EN
          cnt_d   = '0;
          state_d = ST_NORM_ACC;
`else
          state_d = ST_DONE;
`endif
        end else begin
          row_d   = row_q + ADDR_W'(1);
          state_d = ST_DRAIN_RD;
        end
      end
`ifdef CORE_SEQ_NORM_EN
      ST_NORM_ACC: begin
        ctrl_d[BIT_PMEM_RD] = 1'b1;
        pmem_addr_d         = cnt_addr;
        sfp_d               = SFP_ACC;
        if (cnt_q == NQ_LAST) begin
          cnt_d   = '0;
          state_d = ST_NORM_WR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_NORM_WR: begin
        if (cnt_q != NQ_END) begin
          ctrl_d[BIT_PMEM_RD] = 1'b1;
          pmem_addr_d         = cnt_addr;
          sfp_d               = SFP_NORM;
        end
        // The write trails the read by one cycle because of the SFP latency.
        // At cnt = N_Q = 2**ADDR_W, cnt_addr is 0 and the address wraps to
        // all-ones, which is the last row as required.
        if (cnt_q != '0) begin
          norm_wr_d   = 1'b1;
          norm_addr_d = cnt_addr - ADDR_W'(1);
        end
        if (cnt_q == NQ_END) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_LOAD_Q) || (state_d == ST_LOAD_K);
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
  end

  core_seq_inst_pack #(.ADDR_W(ADDR_W)) u_pack (
    .ofifo_rd  (ofifo_rd_d),
    .qk_addr   (qk_addr_d),
    .pmem_addr (pmem_addr_d),
    .ctrl      (ctrl_d),
    .inst      (inst_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      inst_q      <= '0;
      sfp_q       <= SFP_NOP;
      norm_addr_q <= '0;
      norm_wr_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      inst_q      <= inst_d;
      sfp_q       <= sfp_d;
      norm_addr_q <= norm_addr_d;
      norm_wr_q   <= norm_wr_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign inst          = inst_q;
  assign sfp_inst      = sfp_q;
  assign norm_mem_addr = norm_addr_q;
  assign norm_mem_wr   = norm_wr_q;
  assign norm_mem_rd   = 1'b0;
  assign in_ready      = in_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl -- directed bench for core_seq_ctrl.
// DUT "a" uses the default parameters (ADDR_W=4, N_Q=16, N_K=8).
// DUT "b" uses ADDR_W=3, N_Q=8, N_K=8.
// Negedge monitors decode inst and tally per-tile events. Tile-end counts are
// compared with hand-computed values. Define CORE_SEQ_NORM_EN to also cover
// the normalisation phase.
`timescale 1ns/1ps
module tb_core_seq_ctrl;
  import core_seq_pkg::*;

  localparam int AW  = 4, NQ  = 16, NK  = 8, IW  = 2 * AW + 9;
  localparam int AWB = 3, NQB = 8,  NKB = 8, IWB = 2 * AWB + 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, in_valid, fifo_valid;
  logic          in_ready, norm_mem_rd, norm_mem_wr, busy, done;
  logic [IW-1:0] inst;
  logic [1:0]    sfp_inst;
  logic [AW-1:0] norm_mem_addr;

  logic           start_b, in_valid_b, fifo_valid_b;
  logic           in_ready_b, norm_mem_rd_b, norm_mem_wr_b, busy_b, done_b;
  logic [IWB-1:0] inst_b;
  logic [1:0]     sfp_inst_b;
  logic [AWB-1:0] norm_mem_addr_b;

  core_seq_ctrl #(.ADDR_W(AW), .N_Q(NQ), .N_K(NK)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fifo_valid(fifo_valid), .inst(inst), .sfp_inst(sfp_inst), .norm_mem_addr(norm_mem_addr),
    .norm_mem_rd(norm_mem_rd), .norm_mem_wr(norm_mem_wr), .busy(busy), .done(done)
  );

  core_seq_ctrl #(.ADDR_W(AWB), .N_Q(NQB), .N_K(NKB)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .fifo_valid(fifo_valid_b), .inst(inst_b), .sfp_inst(sfp_inst_b), .norm_mem_addr(norm_mem_addr_b),
    .norm_mem_rd(norm_mem_rd_b), .norm_mem_wr(norm_mem_wr_b), .busy(busy_b), .done(done_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- decode of DUT a ----------------
  logic          a_ofr;
  logic [AW-1:0] a_qk, a_pa;
  assign a_ofr = inst[IW-1];
  assign a_qk  = inst[BIT_PMEM_ADDR_LO + AW +: AW];
  assign a_pa  = inst[BIT_PMEM_ADDR_LO +: AW];

  int n_qw, n_kw, n_kr, n_qr, n_ofr, n_pw, n_done, n_kl, n_ex, n_acc, n_nrm, n_nw, seq_err;
  logic          prev_acc, prev_ofr, prev_kl, prev_nrd;
  logic [AW-1:0] prev_nrd_addr;

  always @(negedge clk) begin
    int e;
    e = 0;
    if (start && !busy && !reset) begin
      n_qw <= 0; n_kw <= 0; n_kr <= 0; n_qr <= 0; n_ofr <= 0; n_pw <= 0; n_done <= 0;
      n_kl <= 0; n_ex <= 0; n_acc <= 0; n_nrm <= 0; n_nw <= 0; seq_err <= 0;
      prev_acc <= 1'b0; prev_ofr <= 1'b0; prev_kl <= 1'b0; prev_nrd <= 1'b0;
    end else begin
      if (inst[BIT_QMEM_WR]) begin
        if (!prev_acc || a_qk != AW'(n_qw)) e++;
        n_qw <= n_qw + 1;
      end
      if (inst[BIT_KMEM_WR]) begin
        if (!prev_acc || a_qk != AW'(n_kw)) e++;
        n_kw <= n_kw + 1;
      end
      if (prev_acc && !(inst[BIT_QMEM_WR] || inst[BIT_KMEM_WR])) e++;
      if (inst[BIT_KMEM_RD]) begin
        if (!inst[BIT_KLOAD] || a_qk != AW'(n_kr)) e++;
        n_kr <= n_kr + 1;
      end
      if (inst[BIT_QMEM_RD]) begin
        if (!inst[BIT_EXEC] || a_qk != AW'(n_qr)) e++;
        n_qr <= n_qr + 1;
      end
      if (inst[BIT_KLOAD]) n_kl <= n_kl + 1;
      if (inst[BIT_EXEC])  n_ex <= n_ex + 1;
      if (inst[BIT_KLOAD] && inst[BIT_EXEC]) e++;
      if (prev_kl && inst[BIT_EXEC]) e++;
      if (a_ofr) begin
        if (prev_ofr) e++;
        n_ofr <= n_ofr + 1;
      end
      if (inst[BIT_PMEM_WR]) begin
        if (!prev_ofr || a_pa != AW'(n_pw)) e++;
        n_pw <= n_pw + 1;
      end
      if (done) begin
        if (busy) e++;
        n_done <= n_done + 1;
      end
`ifdef CORE_SEQ_NORM_EN
      if (inst[BIT_PMEM_RD]) begin
        if (sfp_inst == SFP_ACC) begin
          if (a_pa != AW'(n_acc)) e++;
          n_acc <= n_acc + 1;
        end else if (sfp_inst == SFP_NORM) begin
          if (n_acc != NQ || a_pa != AW'(n_nrm)) e++;
          n_nrm <= n_nrm + 1;
        end else begin
          e++;
        end
      end
      if (norm_mem_wr) begin
        if (!prev_nrd || norm_mem_addr != prev_nrd_addr || norm_mem_addr != AW'(n_nw)) e++;
        n_nw <= n_nw + 1;
      end
      prev_nrd      <= inst[BIT_PMEM_RD] && (sfp_inst == SFP_NORM);
      prev_nrd_addr <= a_pa;
`else
      if (sfp_inst != SFP_NOP || norm_mem_wr || inst[BIT_PMEM_RD]) e++;
`endif
      if (norm_mem_rd) e++;
      seq_err  <= seq_err + e;
      prev_acc <= in_valid && in_ready;
      prev_ofr <= a_ofr;
      prev_kl  <= inst[BIT_KLOAD];
    end
  end

  // ---------------- decode of DUT b ----------------
  logic           b_ofr;
  logic [AWB-1:0] b_qk, b_pa;
  assign b_ofr = inst_b[IWB-1];
  assign b_qk  = inst_b[BIT_PMEM_ADDR_LO + AWB +: AWB];
  assign b_pa  = inst_b[BIT_PMEM_ADDR_LO +: AWB];

  int b_qw, b_pw, b_ofr_n, b_done_n, b_err, b_max_qk;

  always @(negedge clk) begin
    int e;
    e = 0;
    if (start_b && !busy_b && !reset) begin
      b_qw <= 0; b_pw <= 0; b_ofr_n <= 0; b_done_n <= 0; b_err <= 0; b_max_qk <= 0;
    end else begin
      if (inst_b[BIT_QMEM_WR]) begin
        if (b_qk != AWB'(b_qw)) e++;
        if (int'(b_qk) > b_max_qk) b_max_qk <= int'(b_qk);
        b_qw <= b_qw + 1;
      end
      if (inst_b[BIT_PMEM_WR]) begin
        if (b_pa != AWB'(b_pw)) e++;
        b_pw <= b_pw + 1;
      end
      if (b_ofr) b_ofr_n <= b_ofr_n + 1;
      if (done_b) b_done_n <= b_done_n + 1;
      b_err <= b_err + e;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (toggle) in_valid = ~in_valid;
      tick();
      if (n_done > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_tile(input string t);
    check_val({t, "_qmem_wr"}, n_qw, 16);
    check_val({t, "_kmem_wr"}, n_kw, 8);
    check_val({t, "_ofifo_rd"}, n_ofr, 16);
    check_val({t, "_pmem_wr"}, n_pw, 16);
    check_val({t, "_done"}, n_done, 1);
    check_val({t, "_seq_err"}, seq_err, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; fifo_valid = 1'b1;
    start_b = 1'b0; in_valid_b = 1'b1; fifo_valid_b = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_val("rst_inst", inst, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_sfp", sfp_inst, 0);
    check_val("rst_norm_wr", norm_mem_wr, 0);

    // 1: constant in_valid, full tile
    in_valid = 1'b1;
    pulse_start();
    check_val("t1_busy_after_start", busy, 1);
    check_val("t1_in_ready", in_ready, 1);
    wait_done(1000, 1'b0, ok);
    check_val("t1_finished", ok, 1);
    check_tile("t1");
    check_val("t1_kmem_rd", n_kr, 8);
    check_val("t1_kload_cycles", n_kl, 9);
    check_val("t1_qmem_rd", n_qr, 16);
    check_val("t1_exec_cycles", n_ex, 17);
`ifdef CORE_SEQ_NORM_EN
    check_val("t6_sfp_acc_reads", n_acc, 16);
    check_val("t6_sfp_norm_reads", n_nrm, 16);
    check_val("t6_norm_mem_wr", n_nw, 16);
`endif
    tick();
    check_val("t1_busy_idle", busy, 0);

    // 2: in_valid toggling during the loads
    in_valid = 1'b0;
    pulse_start();
    wait_done(1000, 1'b1, ok);
    check_val("t2_finished", ok, 1);
    check_tile("t2");
    in_valid = 1'b1;
    tick();

    // 3: fifo_valid held low -> drain stalls, then resumes
    fifo_valid = 1'b0;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (n_qr == 16 && !inst[BIT_EXEC]) break;
      tick();
    end
    check_val("t3_reached_drain", n_qr, 16);
    repeat (20) tick();
    check_val("t3_stall_ofifo_rd", n_ofr, 0);
    check_val("t3_stall_pmem_wr", n_pw, 0);
    check_val("t3_stall_busy", busy, 1);
    fifo_valid = 1'b1;
    wait_done(1000, 1'b0, ok);
    check_val("t3_finished", ok, 1);
    check_tile("t3");
    tick();

    // 4a: start pulsed during EXEC is ignored
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (inst[BIT_EXEC]) break;
      tick();
    end
    check_val("t4_in_exec", inst[BIT_EXEC], 1);
    pulse_start();
    wait_done(1000, 1'b0, ok);
    check_val("t4_finished", ok, 1);
    repeat (10) tick();
    check_val("t4_single_done", n_done, 1);
    check_val("t4_busy_after", busy, 0);
    check_val("t4_ofifo_rd", n_ofr, 16);

    // 4b: reset in the third KLOAD cycle
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (inst[BIT_KLOAD]) break;
      tick();
    end
    check_val("t4_in_kload", inst[BIT_KLOAD], 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("t4_rst_inst", inst, 0);
    check_val("t4_rst_busy", busy, 0);
    check_val("t4_rst_in_ready", in_ready, 0);
    repeat (30) tick();
    check_val("t4_rst_no_done", n_done, 0);
    check_val("t4_rst_idle_inst", inst, 0);

    // 5: ADDR_W=3, N_Q=8, N_K=8 instance
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (b_done_n > 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("t5_finished", ok, 1);
    repeat (5) tick();
    check_val("t5_qmem_wr", b_qw, 8);
    check_val("t5_max_qk_addr", b_max_qk, 7);
    check_val("t5_pmem_wr", b_pw, 8);
    check_val("t5_ofifo_rd", b_ofr_n, 8);
    check_val("t5_done", b_done_n, 1);
    check_val("t5_seq_err", b_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
